serial_adder: RTL

Bit-serial ripple adder: the addition counterpart of the combinational half subtractor in the adders-substractors collection. It computes a WIDTH-bit sum plus carry-out one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. A start/busy/done handshake lets a controller or testbed issue back-to-back additions. It trades latency for area against the combinational adders.

---
 rtl/adders_pkg.sv | 12 +
 rtl/full_add.sv | 13 +
 rtl/serial_adder.sv | 90 +++++++++
 3 files changed

// File: rtl/adders_pkg.sv
// Shared types and constants for the adder cell collection.
package adders_pkg;

  localparam int unsigned ADDER_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } serial_state_t;

endpackage

// File: rtl/full_add.sv
// One-bit full adder cell, purely combinational.
module full_add (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_cin;
  assign o_co = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, WIDTH cycles per sum.
module serial_adder
  import adders_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  serial_state_t    r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_next;

  full_add u_full_add (
    .i_a  (r_a_sh[0]),
    .i_b  (r_b_sh[0]),
    .i_cin(r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // New sum bit enters at the MSB; written as shifts so WIDTH=1 needs no special case.
  assign w_sum_next = (r_sum_sh >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_a_sh   <= i_a;
            r_b_sh   <= i_b;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sum_sh <= w_sum_next;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_carry  <= w_co;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_co;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_DONE);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule
